// File: rtl/serial_led_echo.sv
`default_nettype none
// ============================================================================
//  Module      : serial_led_echo
//  Description : 8N1 UART receiver driving LEDs. With SERIAL_ECHO_EN defined,
//                good bytes are queued in a small FIFO and re-sent on usb_tx
//                by a UART transmitter. Without it, usb_tx loops back usb_rx.
//  Config      : SERIAL_ECHO_EN (undefined = loopback, no FIFO/TX)
//  Revision    : 1.0  initial release
// ============================================================================
module serial_led_echo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 1_000_000,
    parameter int LED_WIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 usb_rx,
    output logic                 usb_tx,
    input  logic                 tx_hold,
    output logic [LED_WIDTH-1:0] led,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overflow
);

    localparam int c_CPB   = CLK_FREQ / BAUD;
    localparam int c_HALF  = c_CPB / 2;
    localparam int c_CNT_W = $clog2(c_CPB);

    localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(c_CPB - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF - 1);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    logic               r_rx_meta;
    logic               r_rx_sync;
    logic               r_rx_prev;
    rx_state_t          r_rx_state;
    rx_state_t          w_rx_state_n;
    logic [c_CNT_W-1:0] r_rx_cnt;
    logic [c_CNT_W-1:0] w_rx_cnt_n;
    logic [2:0]         r_rx_bit;
    logic [2:0]         w_rx_bit_n;
    logic [7:0]         r_rx_shift;
    logic [7:0]         w_rx_shift_n;
    logic               w_rx_good;
    logic               w_rx_bad;
    logic               r_rx_valid;
    logic               r_frame_err;
    logic [LED_WIDTH-1:0] r_led;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection;
    // all preset high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= usb_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // RX state register and registered pulse/LED outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state  <= RX_IDLE;
            r_rx_cnt    <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_led       <= '0;
        end else begin
            r_rx_state  <= w_rx_state_n;
            r_rx_cnt    <= w_rx_cnt_n;
            r_rx_bit    <= w_rx_bit_n;
            r_rx_shift  <= w_rx_shift_n;
            r_rx_valid  <= w_rx_good;
            r_frame_err <= w_rx_bad;
            if (w_rx_good) begin
                r_led <= r_rx_shift[LED_WIDTH-1:0];
            end
        end
    end

    // RX next-state: mid-bit sampling, LSB first, stop-bit validation.
    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_good    = 1'b0;
        w_rx_bad     = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_rx_state_n = RX_START;
                    w_rx_cnt_n   = '0;
                end
            end
            RX_START: begin
                if (r_rx_cnt == c_HALF_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_bit_n   = '0;
                    // A line already back high at mid start bit is a glitch.
                    w_rx_state_n = r_rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {r_rx_sync, r_rx_shift[7:1]};
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_n = RX_STOP;
                    end else begin
                        w_rx_bit_n = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == c_BIT_LAST) begin
                    w_rx_cnt_n = '0;
                    if (r_rx_sync) begin
                        w_rx_good    = 1'b1;
                        w_rx_state_n = RX_IDLE;
                    end else begin
                        w_rx_bad     = 1'b1;
                        w_rx_state_n = RX_WAIT_HIGH;
                    end
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                // A low stop bit means the line may still be in a break;
                // wait for idle before hunting for the next start edge.
                if (r_rx_sync) begin
                    w_rx_state_n = RX_IDLE;
                end
            end
            default: begin
                w_rx_state_n = RX_IDLE;
            end
        endcase
    end

    assign led       = r_led;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;

`ifdef SERIAL_ECHO_EN
    // ------------------------------------------------------------------
    // Echo FIFO
    // ------------------------------------------------------------------
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_STOP_LAST  = c_CNT_W'(c_CPB - 2);
    localparam logic [c_PTR_W:0]   c_FIFO_FULL  = (c_PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]       r_fifo_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0] r_fifo_cnt;
    logic             r_overflow;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_write;
    logic [7:0]       w_fifo_head;

    assign w_push      = r_rx_valid;
    assign w_full      = (r_fifo_cnt == c_FIFO_FULL);
    assign w_empty     = (r_fifo_cnt == '0);
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_write     = w_push && (!w_full || w_pop);
    assign w_fifo_head = r_fifo_mem[r_rd_ptr];

    // FIFO storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_fifo_mem[r_wr_ptr] <= r_rx_shift;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_write, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    tx_state_t          r_tx_state;
    tx_state_t          w_tx_state_n;
    logic [c_CNT_W-1:0] r_tx_cnt;
    logic [c_CNT_W-1:0] w_tx_cnt_n;
    logic [2:0]         r_tx_bit;
    logic [2:0]         w_tx_bit_n;
    logic [7:0]         r_tx_shift;
    logic [7:0]         w_tx_shift_n;
    logic               r_usb_tx;
    logic               w_tx_out_n;

    // TX state register; the line level is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_usb_tx   <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tx_shift <= w_tx_shift_n;
            r_usb_tx   <= w_tx_out_n;
        end
    end

    // TX next-state. STOP runs one cycle short because the following IDLE
    // cycle also drives high, so the stop bit is exactly one bit long even
    // when the next frame is popped straight away.
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tx_shift_n = r_tx_shift;
        w_tx_out_n   = r_usb_tx;
        w_pop        = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_out_n = 1'b1;
                if (!w_empty && !tx_hold) begin
                    w_pop        = 1'b1;
                    w_tx_shift_n = w_fifo_head;
                    w_tx_cnt_n   = '0;
                    w_tx_out_n   = 1'b0;
                    w_tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = '0;
                    w_tx_out_n   = r_tx_shift[0];
                    w_tx_state_n = TX_DATA;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == c_BIT_LAST) begin
                    w_tx_cnt_n = '0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_out_n   = 1'b1;
                        w_tx_state_n = TX_STOP;
                    end else begin
                        w_tx_bit_n   = r_tx_bit + 1'b1;
                        w_tx_shift_n = r_tx_shift >> 1;
                        w_tx_out_n   = r_tx_shift[1];
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == c_STOP_LAST) begin
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = TX_IDLE;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            default: begin
                w_tx_out_n   = 1'b1;
                w_tx_state_n = TX_IDLE;
            end
        endcase
    end

    assign usb_tx   = r_usb_tx;
    assign overflow = r_overflow;
`else
    // Echo path absent: plain loopback, hold input has no effect.
    logic       w_unused_hold;
    logic [7:0] w_unused_rx_byte;

    assign w_unused_hold    = tx_hold;
    assign w_unused_rx_byte = r_rx_shift;
    assign usb_tx           = usb_rx;
    assign overflow         = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_led_echo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_led_echo
//  Description : Randomised self-checking bench for serial_led_echo against a
//                byte-level reference model (10 clocks per bit).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_led_echo;

    localparam int c_CPB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       usb_rx = 1'b1;
    logic       tx_hold = 1'b0;
    logic       usb_tx, rx_valid, frame_err, overflow;
    logic [7:0] led;
    logic       usb_tx4, rx_valid4, frame_err4, overflow4;
    logic [3:0] led4;

    serial_led_echo #(
        .CLK_FREQ(100_000_000), .BAUD(10_000_000), .LED_WIDTH(8), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .usb_rx(usb_rx), .usb_tx(usb_tx), .tx_hold(tx_hold),
        .led(led), .rx_valid(rx_valid), .frame_err(frame_err), .overflow(overflow)
    );

    serial_led_echo #(
        .CLK_FREQ(100_000_000), .BAUD(10_000_000), .LED_WIDTH(4), .FIFO_DEPTH(4)
    ) dut4 (
        .clk(clk), .rst(rst), .usb_rx(usb_rx), .usb_tx(usb_tx4), .tx_hold(tx_hold),
        .led(led4), .rx_valid(rx_valid4), .frame_err(frame_err4), .overflow(overflow4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pulse counters sampled on the falling edge.
    int rv_cnt = 0, rv4_cnt = 0, fe_cnt = 0, fe4_cnt = 0, rv_cyc = 0;
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            rv_cnt++;
            rv_cyc = cyc;
        end
        if (rx_valid4 === 1'b1) rv4_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (frame_err4 === 1'b1) fe4_cnt++;
    end

    // Reference model state
    int         exp_rv = 0;
    int         exp_fe = 0;
    logic [7:0] exp_led = 8'h00;
    logic [7:0] exp_q[$];
    logic [7:0] tx_got[$];
    int         fall_q[$];

`ifdef SERIAL_ECHO_EN
    // Line decoder for usb_tx: records frame start cycles and decoded bytes.
    int         mon_cnt = 0;
    bit         mon_busy = 1'b0;
    logic       mon_prev = 1'b1;
    logic [7:0] mon_byte = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            mon_busy = 1'b0;
            mon_prev = 1'b1;
        end else begin
            if (mon_busy) begin
                mon_cnt++;
                if (mon_cnt == 5) begin
                    check("tx_start_bit", usb_tx, 1'b0);
                end else if (mon_cnt >= 15 && mon_cnt <= 85 && (mon_cnt - 15) % 10 == 0) begin
                    mon_byte[(mon_cnt - 15) / 10] = usb_tx;
                end else if (mon_cnt == 95) begin
                    check("tx_stop_bit", usb_tx, 1'b1);
                    tx_got.push_back(mon_byte);
                    mon_busy = 1'b0;
                end
            end else if (mon_prev && !usb_tx) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                fall_q.push_back(cyc);
            end
            mon_prev = usb_tx;
        end
    end
`endif

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_rx();
        check("rx_valid_count", rv_cnt, exp_rv);
        check("rx_valid4_count", rv4_cnt, exp_rv);
        check("frame_err_count", fe_cnt, exp_fe);
        check("frame_err4_count", fe4_cnt, exp_fe);
        check("led", led, exp_led);
        check("led4", led4, exp_led[3:0]);
    endtask

    // Drive one 8N1 frame; ok=0 sends a low stop bit. Updates the model.
    task automatic send_frame(input logic [7:0] b, input bit ok);
        logic [9:0] fr;
        fr = {ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            usb_rx = fr[i];
            for (int k = 0; k < c_CPB; k++) begin
                tick();
`ifndef SERIAL_ECHO_EN
                if (k == c_CPB / 2) check("loopback", usb_tx, usb_rx);
`endif
            end
        end
        usb_rx = 1'b1;
        tick(3);
        if (ok) begin
            exp_rv++;
            exp_led = b;
`ifdef SERIAL_ECHO_EN
            exp_q.push_back(b);
`endif
        end else begin
            exp_fe++;
            tick(20);
        end
        check_rx();
    endtask

    // Wait (bounded) for every expected echo byte, then compare in order.
    task automatic drain_compare();
        int t;
        t = 0;
        while (tx_got.size() < exp_q.size() && t < 2000) begin
            tick();
            t++;
        end
        check("echo_count", tx_got.size(), exp_q.size());
        while (exp_q.size() > 0 && tx_got.size() > 0) begin
            check("echo_byte", tx_got.pop_front(), exp_q.pop_front());
        end
        exp_q.delete();
        tx_got.delete();
    endtask

    initial begin
        int   fb;
        int   d;
        logic [7:0] rb;
        bit   rok;

        // 1: reset held for three cycles while the line toggles.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            usb_rx = 1'($urandom);
            tick();
        end
        usb_rx = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_usb_tx", usb_tx, 1'b1);
        check("reset_usb_tx4", usb_tx4, 1'b1);
        check("reset_overflow", overflow, 1'b0);
        check_rx();
        tick(20);

        // 2: good byte 0xA5.
        fb = fall_q.size();
        send_frame(8'hA5, 1'b1);
`ifdef SERIAL_ECHO_EN
        drain_compare();
        check("echo_a5_frames", fall_q.size(), fb + 1);
        if (fall_q.size() > fb) begin
            d = fall_q[fb] - rv_cyc;
            check("tx_start_latency_ok", (d >= 1 && d <= 2), 1'b1);
        end
`endif
        tick(20);

        // 3: bad stop bit.
        fb = fall_q.size();
        send_frame(8'h3C, 1'b0);
        check("ferr_usb_tx_idle", usb_tx, 1'b1);
        check("ferr_no_echo", fall_q.size(), fb);

        // 4: short glitch.
        usb_rx = 1'b0;
        tick(4);
        usb_rx = 1'b1;
        tick(30);
        check_rx();

        // Random frames with random stop-bit errors and gaps.
        for (int n = 0; n < 10; n++) begin
            rb  = 8'($urandom);
            rok = ($urandom_range(0, 3) != 0);
            send_frame(rb, rok);
            tick($urandom_range(2, 15));
        end
`ifdef SERIAL_ECHO_EN
        drain_compare();
`endif
        tick(30);

        // 5: tx_hold with six bytes, overflow on the fifth.
        tx_hold = 1'b1;
        fb = fall_q.size();
        for (int i = 1; i <= 6; i++) begin
            send_frame(8'(i), 1'b1);
`ifdef SERIAL_ECHO_EN
            check("overflow_hold", overflow, (i >= 5));
            check("overflow4_hold", overflow4, (i >= 5));
`else
            check("overflow_tied", overflow, 1'b0);
`endif
        end
`ifdef SERIAL_ECHO_EN
        check("hold_no_tx", fall_q.size(), fb);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        tx_hold = 1'b0;
        drain_compare();
        for (int i = 1; i < 4; i++) begin
            if (fall_q.size() > fb + i) begin
                check("back_to_back_gap", fall_q[fb + i] - fall_q[fb + i - 1], 10 * c_CPB);
            end
        end
        tick(150);
        check("no_fifth_frame", fall_q.size(), fb + 4);
        check("overflow_sticky", overflow, 1'b1);
`else
        tx_hold = 1'b0;
`endif
        tick(20);

        // 6: reset while TX (echo of 0x55) and a new RX frame are in flight.
        fb = fall_q.size();
        send_frame(8'h55, 1'b1);
`ifdef SERIAL_ECHO_EN
        d = 0;
        while (fall_q.size() == fb && d < 50) begin
            tick();
            d++;
        end
        check("tx55_started", fall_q.size(), fb + 1);
`endif
        usb_rx = 1'b0;
        tick(30);
        rst = 1'b1;
        usb_rx = 1'b1;
        tick();
        exp_led = 8'h00;
        check("midframe_reset_usb_tx", usb_tx, 1'b1);
        check("midframe_reset_overflow", overflow, 1'b0);
        check("midframe_reset_led", led, 8'h00);
        check("midframe_reset_led4", led4, 4'h0);
        rst = 1'b0;
        exp_q.delete();
        tx_got.delete();
        fb = fall_q.size();
        tick(200);
        check("post_reset_no_tx", fall_q.size(), fb);
        check("post_reset_usb_tx4", usb_tx4, 1'b1);
        check_rx();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog timeout");
    end

endmodule
`default_nettype wire
